// File: rtl/board_test_pkg.sv
// Shared types and constants for the board-test LED sequencer: mode encoding,
// LED width and the pattern each mode starts from.
package board_test_pkg;

  localparam int LED_WIDTH = 6;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    SHIFT = 2'd1,
    BLINK = 2'd2,
    PAUSE = 2'd3
  } mode_e;

  localparam logic [LED_WIDTH-1:0] INIT_COUNT = 6'b000000;
  localparam logic [LED_WIDTH-1:0] INIT_SHIFT = 6'b000001;
  localparam logic [LED_WIDTH-1:0] INIT_BLINK = 6'b000000;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic mode_e next_mode(input mode_e m);
    mode_e r;
    r = COUNT;
    case (m)
      COUNT:   r = SHIFT;
      SHIFT:   r = BLINK;
      BLINK:   r = PAUSE;
      PAUSE:   r = COUNT;
      default: r = COUNT;
    endcase
    return r;
  endfunction

  // PAUSE has no fixed start value: it freezes whatever was showing.
  function automatic logic [LED_WIDTH-1:0] init_pattern(input mode_e m,
                                                        input logic [LED_WIDTH-1:0] cur);
    logic [LED_WIDTH-1:0] r;
    r = cur;
    case (m)
      COUNT:   r = INIT_COUNT;
      SHIFT:   r = INIT_SHIFT;
      BLINK:   r = INIT_BLINK;
      PAUSE:   r = cur;
      default: r = cur;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/board_test_debounce.sv
// One pushbutton: 2-flop synchronizer, counting debouncer and a one-cycle
// press pulse on the released->pressed transition of the debounced level.
module board_test_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    vld_q, vld_d;
  logic          armed_q, armed_d;

  // armed only after a genuinely sampled released level, so a button held
  // through reset release cannot produce a press until it is let go.
  always_comb begin
    sync1_d = btn_n;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    armed_d = armed_q | (vld_q[1] & sync2_q);
    level_d = level_q;
    cnt_d   = '0;
    press   = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
        press   = armed_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/board_test_led_sequencer.sv
// Board bring-up LED sequencer: two buttons select mode and direction, a
// prescaler paces the pattern. Optional PWM dimming under LED_SEQ_PWM_EN.
module board_test_led_sequencer
  import board_test_pkg::*;
#(
  parameter int TICK_DIV        = 65536,
  parameter int DEBOUNCE_CYCLES = 1024
`ifdef LED_SEQ_PWM_EN
  , parameter int PWM_DUTY      = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s1_n,
  input  logic                 s2_n,
  output logic [LED_WIDTH-1:0] led_n,
  output logic [1:0]           mode,
  output logic                 tick
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic                 s1_press, s2_press;
  mode_e                mode_q, mode_d;
  logic                 dir_q, dir_d;
  logic [LED_WIDTH-1:0] pattern_q, pattern_d;
  logic [PW-1:0]        presc_q, presc_d;

  board_test_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_s1 (
    .clk   (clk),
    .rst   (rst),
    .btn_n (s1_n),
    .press (s1_press)
  );

  board_test_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_s2 (
    .clk   (clk),
    .rst   (rst),
    .btn_n (s2_n),
    .press (s2_press)
  );

  assign tick = (presc_q == PRE_MAX);

  // Button events outrank the tick: a coinciding step is simply dropped.
  always_comb begin
    mode_d    = mode_q;
    dir_d     = dir_q;
    pattern_d = pattern_q;
    presc_d   = tick ? '0 : presc_q + 1'b1;
    if (s1_press && s2_press) begin
      pattern_d = init_pattern(mode_q, pattern_q);
      presc_d   = '0;
    end else if (s1_press) begin
      mode_d    = next_mode(mode_q);
      pattern_d = init_pattern(mode_d, pattern_q);
      presc_d   = '0;
    end else if (s2_press) begin
      dir_d = ~dir_q;
    end else if (tick) begin
      case (mode_q)
        COUNT:   pattern_d = (dir_q == DIR_UP) ? pattern_q + 1'b1 : pattern_q - 1'b1;
        SHIFT:   pattern_d = (dir_q == DIR_UP) ? {pattern_q[LED_WIDTH-2:0], pattern_q[LED_WIDTH-1]}
                                               : {pattern_q[0], pattern_q[LED_WIDTH-1:1]};
        BLINK:   pattern_d = ~pattern_q;
        PAUSE:   pattern_d = pattern_q;
        default: pattern_d = pattern_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= COUNT;
      dir_q     <= DIR_UP;
      pattern_q <= '0;
      presc_q   <= '0;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      pattern_q <= pattern_d;
      presc_q   <= presc_d;
    end
  end

  assign mode = mode_q;

`ifdef LED_SEQ_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_on;

  // Duty compared in 5 bits so PWM_DUTY=16 means always on.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 4'd1;
    pwm_on    = ({1'b0, pwm_cnt_q} < 5'(PWM_DUTY));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt_q <= 4'd0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end

  assign led_n = ~(pattern_q & {LED_WIDTH{pwm_on}});
`else
  assign led_n = ~pattern_q;
`endif

endmodule

// File: tb/tb_board_test_led_sequencer.sv
// Directed bench for board_test_led_sequencer with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Edge numbers in comments count posedges since the most recent reset release.
module tb_board_test_led_sequencer;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       s1_n = 1'b1;
  logic       s2_n = 1'b1;
  logic [5:0] led_n;
  logic [1:0] mode;
  logic       tick;

  int n_pass = 0;
  int n_chk  = 0;

  localparam logic [5:0] PATS_RIGHT [6] = '{6'b100000, 6'b010000, 6'b001000,
                                            6'b000100, 6'b000010, 6'b000001};

  always #5 clk = ~clk;

  board_test_led_sequencer #(
    .TICK_DIV        (4),
    .DEBOUNCE_CYCLES (3)
`ifdef LED_SEQ_PWM_EN
    , .PWM_DUTY      (4)
`endif
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .s1_n  (s1_n),
    .s2_n  (s2_n),
    .led_n (led_n),
    .mode  (mode),
    .tick  (tick)
  );

`ifdef LED_SEQ_PWM_EN
  logic [3:0] pwm_model;
  always @(posedge clk or posedge rst) begin
    if (rst) pwm_model <= 4'd0;
    else     pwm_model <= pwm_model + 4'd1;
  end
  function automatic logic [5:0] exp_led(input logic [5:0] pat);
    return ~(pat & {6{pwm_model < 4'd4}});
  endfunction
`else
  function automatic logic [5:0] exp_led(input logic [5:0] pat);
    return ~pat;
  endfunction
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_led(input string tag, input logic [5:0] pat);
    chk(tag, 32'(led_n), 32'(exp_led(pat)));
  endtask

  task automatic chk_mode(input string tag, input logic [1:0] m);
    chk(tag, 32'(mode), 32'(m));
  endtask

  task automatic chk_tick(input string tag, input logic t);
    chk(tag, 32'(tick), 32'(t));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    chk_led("rst_led", 6'b000000);
    chk_mode("rst_mode", 2'd0);
    chk_tick("rst_tick", 1'b0);
    rst = 1'b0;

    // free-running COUNT up: tick after edges 3,7,..., step on edges 4,8,...
    for (int i = 1; i <= 20; i++) begin
      step(1);
      chk_tick("cnt_tick", (i % 4) == 3);
      chk_led("cnt_led", 6'(i / 4));
      if (i == 17) begin
        s1_n = 1'b0;
        s2_n = 1'b0;
      end
    end

    // both buttons accepted together at e22 while pattern is 000101
    step(2);
    chk_mode("both_cnt_mode", 2'd0);
    chk_led("both_cnt_led", 6'b000000);
    s1_n = 1'b1;
    s2_n = 1'b1;
    step(3);
    chk_tick("both_presc_clr", 1'b1);
    step(1);
    chk_led("both_dir_kept", 6'b000001);

    // 2-cycle glitch on s1 must not count as a press
    step(1);
    s1_n = 1'b0;
    step(2);
    s1_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk_mode("glitch_mode", 2'd0);
    end

    // real press: accepted on e38, which is also a tick edge
    s1_n = 1'b0;
    step(4);
    chk_mode("press_early", 2'd0);
    step(1);
    chk_mode("press_shift", 2'd1);
    chk_led("press_shift_led", 6'b000001);
    s1_n = 1'b1;
    step(1);
    chk_tick("presc0_a", 1'b0);
    step(1);
    chk_tick("presc0_b", 1'b0);
    step(1);
    chk_tick("presc0_c", 1'b1);
    step(1);
    chk_led("rot_left", 6'b000010);

    // s2 toggles direction; mode and pattern untouched
    step(1);
    s2_n = 1'b0;
    step(5);
    chk_mode("s2_mode", 2'd1);
    chk_led("s2_led", 6'b000100);
    s2_n = 1'b1;
    step(2);
    chk_led("rot_right", 6'b000010);

    // both pressed in SHIFT reloads 000001 and clears prescaler
    step(3);
    s1_n = 1'b0;
    s2_n = 1'b0;
    step(5);
    chk_mode("both_shift_mode", 2'd1);
    chk_led("both_shift_led", 6'b000001);
    s1_n = 1'b1;
    s2_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(3);
      chk_tick("ror_tick", 1'b1);
      step(1);
      chk_led("ror_led", PATS_RIGHT[k]);
    end

    // SHIFT -> BLINK
    s1_n = 1'b0;
    step(5);
    chk_mode("blink_mode", 2'd2);
    chk_led("blink_init", 6'b000000);
    s1_n = 1'b1;
    step(3);
    chk_tick("blink_tick", 1'b1);
    step(1);
    chk_led("blink_inv", 6'b111111);

    // BLINK -> PAUSE while pattern is 111111 (press on e101)
    step(5);
    s1_n = 1'b0;
    step(5);
    chk_mode("pause_mode", 2'd3);
    chk_led("pause_hold", 6'b111111);
    s1_n = 1'b1;
    step(3);
    chk_tick("pause_tick", 1'b1);
    step(1);
    chk_led("pause_still", 6'b111111);

    // PAUSE -> COUNT, then down-count wrap (dir is down)
    step(1);
    s1_n = 1'b0;
    step(5);
    chk_mode("count_mode", 2'd0);
    chk_led("count_init", 6'b000000);
    s1_n = 1'b1;
    step(3);
    chk_tick("down_tick", 1'b1);
    step(1);
    chk_led("down_wrap", 6'b111111);

    // press lands exactly on a tick edge (e123): step discarded
    step(3);
    s1_n = 1'b0;
    step(4);
    chk_tick("coin_tick", 1'b1);
    chk_led("coin_pre", 6'b111110);
    step(1);
    chk_mode("coin_mode", 2'd1);
    chk_led("coin_led", 6'b000001);
    s1_n = 1'b1;

    // into BLINK, let one step happen, then async reset mid-run with s1 held
    step(5);
    s1_n = 1'b0;
    step(5);
    chk_mode("blink2_mode", 2'd2);
    s1_n = 1'b1;
    step(4);
    chk_led("blink2_inv", 6'b111111);
    rst  = 1'b1;
    s1_n = 1'b0;
    #1;
    chk_led("arst_led", 6'b000000);
    chk_mode("arst_mode", 2'd0);
    chk_tick("arst_tick", 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // button held through reset release: no press
    step(3);
    chk_tick("first_tick", 1'b1);
    step(1);
    chk_led("first_step", 6'b000001);
    step(4);
    chk_mode("held_no_press", 2'd0);
    s1_n = 1'b1;
    step(6);
    s1_n = 1'b0;
    step(4);
    chk_mode("repress_early", 2'd0);
    step(1);
    chk_mode("repress_mode", 2'd1);
    s1_n = 1'b1;
    step(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/board_test_led_sequencer.md
BOARD_TEST_LED_SEQUENCER -- requirements
Module: board_test_led_sequencer

Interface
REQ-001 Parameter: TICK_DIV, 65536, clk cycles per pattern step; legal range 2..2^24.
REQ-002 Parameter: DEBOUNCE_CYCLES, 1024, consecutive stable synchronized samples needed to accept a button level; legal range 2..2^16.
REQ-003 Port: clk  in  1  single system clock; all state on posedge clk.
REQ-004 Port: rst  in  1  asynchronous, active-high reset.
REQ-005 Port: s1_n  in  1  raw pushbutton 1, active-low, asynchronous to clk.
REQ-006 Port: s2_n  in  1  raw pushbutton 2, active-low, asynchronous to clk.
REQ-007 Port: led_n  out  6  LED drive, active-low; bit 0 = LED1.
REQ-008 Port: mode  out  2  current mode: 0 COUNT, 1 SHIFT, 2 BLINK, 3 PAUSE.
REQ-009 Port: tick  out  1  one-cycle strobe marking each pattern step.

Function
REQ-010 Prescaler: counts 0..TICK_DIV-1, wraps to 0; tick=1 for exactly the cycle in which the count equals TICK_DIV-1.
REQ-011 Each button: 2-flop synchronizer, then debounce; the debounced level updates only after DEBOUNCE_CYCLES consecutive equal samples differing from it; any differing sample restarts the count.
REQ-012 Press event: one-cycle pulse when a debounced level goes released->pressed; releases generate no event; holding generates no repeat.
REQ-013 Mode FSM, s1 press alone: COUNT->SHIFT->BLINK->PAUSE->COUNT.
REQ-014 s2 press alone: toggles dir (reset value up); mode unchanged.
REQ-015 s1 and s2 press events in the same cycle: pattern reloads initial value of current mode, prescaler cleared, mode and dir unchanged.
REQ-016 On any mode change: pattern loads new mode's initial value (COUNT 000000, SHIFT 000001, BLINK 000000, PAUSE holds current), prescaler cleared to 0.
REQ-017 On tick, COUNT: pattern +1 (up) or -1 (down), modulo 64 (111111+1 -> 000000, 000000-1 -> 111111).
REQ-018 On tick, SHIFT: rotate left (up) or right (down) by 1; bit5 wraps to bit0 and vice versa.
REQ-019 On tick, BLINK: pattern <= ~pattern; dir ignored.
REQ-020 PAUSE: pattern holds; prescaler and tick keep running.
REQ-021 A press event coinciding with tick takes priority; the tick step is discarded that cycle.
REQ-022 led_n = ~pattern (subject to REQ-027), zero cycles after the pattern register; mode output equals FSM state register.

Reset
REQ-023 On rst assertion, asynchronously: pattern 000000 (led_n 111111), mode COUNT, dir up, prescaler 0, tick 0, debounced levels released, debounce counts 0, synchronizers released.
REQ-024 Reset asserted mid-step or mid-debounce discards all progress; no press event is generated for a button held through reset release until it is released and pressed again.
REQ-025 First tick after reset release occurs TICK_DIV cycles after the first active clk edge.

Configuration
REQ-026 Macro LED_SEQ_PWM_EN: when defined, adds parameter PWM_DUTY (default 8, range 0..16) and a free-running 4-bit PWM counter (reset 0).
REQ-027 With LED_SEQ_PWM_EN: led_n[i] = ~(pattern[i] & (pwm_cnt < PWM_DUTY)); PWM_DUTY 0 = all off, 16 = fully on. Without it: led_n = ~pattern and no PWM logic exists.

Structure
REQ-028 Shared package board_test_pkg holds: mode enum (COUNT, SHIFT, BLINK, PAUSE, 2-bit), LED_WIDTH=6, mode initial-pattern constants.
REQ-029 Sub-module board_test_debounce (synchronizer + debounce + press pulse), instantiated once per button, parameterized by DEBOUNCE_CYCLES.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3, PWM off unless stated)
REQ-030 Reset release, no buttons, 20 cycles -> tick on cycles 4, 8, 12, 16, 20; led_n 111111, 111110, 111101, 111100, 111011, 111010.
REQ-031 s1_n low 2 cycles then high -> no press, mode stays 0; s1_n low 5 cycles -> exactly one press, mode 1, led_n 111110, prescaler 0.
REQ-032 SHIFT, s2 press, 6 ticks from 000001 -> pattern 100000, 010000, ..., 000001 (rotate-right wrap verified).
REQ-033 COUNT at 000000, dir down, one tick -> pattern 111111, led_n 000000; press s1 on a tick cycle -> mode 1, pattern 000001, no step applied.
REQ-034 s1 and s2 press same cycle in COUNT at 000101 -> pattern 000000, mode 0, dir unchanged; rst pulse during BLINK -> led_n 111111, mode 0 same cycle.
REQ-035 LED_SEQ_PWM_EN, PWM_DUTY=4, pattern 111111 -> led_n 000000 for 4 of every 16 cycles, 111111 otherwise.
